// File: rtl/conv2d_engine.sv
// conv2d_engine
//   Streams a KSIZE x KSIZE signed kernel from kernel memory into a local
//   register file, then slides it over an IMG_H x IMG_W row-major feature map
//   held in image memory. Stride is set at run time. One signed accumulated
//   result is produced per output pixel, with optional ReLU clamping.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_start                 start pulse; only acted on while idle
//   i_stride, i_relu        stride (0 means 1) and ReLU enable; latched at start
//   i_img_base, i_ker_base  base addresses of pixel (0,0) and tap (0,0); latched
//   o_ker_addr/o_ker_rd     kernel read port; i_ker_data returns one cycle later
//   o_img_addr/o_img_rd     image read port; i_img_data returns one cycle later
//   o_res_data/_row/_col    result and its output coordinates
//   o_res_valid/i_res_ready result handshake
//   o_busy                  high whenever the engine is not idle
//   o_done                  one-cycle pulse after the last result is accepted
module conv2d_engine #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(KSIZE*KSIZE)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [2:0]               i_stride,
  input  logic                     i_relu,
  input  logic [ADDR_W-1:0]        i_img_base,
  input  logic [ADDR_W-1:0]        i_ker_base,
  output logic [ADDR_W-1:0]        o_ker_addr,
  output logic                     o_ker_rd,
  input  logic signed [DATA_W-1:0] i_ker_data,
  output logic [ADDR_W-1:0]        o_img_addr,
  output logic                     o_img_rd,
  input  logic signed [DATA_W-1:0] i_img_data,
  output logic signed [ACC_W-1:0]  o_res_data,
  output logic [7:0]               o_res_row,
  output logic [7:0]               o_res_col,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int NTAP  = KSIZE*KSIZE;
  localparam int TAP_W = $clog2(NTAP+1);
  localparam int IDX_W = $clog2(NTAP);
  localparam int KC_W  = $clog2(KSIZE+1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Negative results clamp to zero when ReLU is enabled.
  function automatic logic signed [ACC_W-1:0] relu_clamp(
    input logic signed [ACC_W-1:0] v,
    input logic                    en
  );
    if (en && v[ACC_W-1]) return '0;
    return v;
  endfunction

  // Full-precision product widened (sign-extended) to accumulator width.
  function automatic logic signed [ACC_W-1:0] widen_prod(
    input logic signed [2*DATA_W-1:0] p
  );
    return ACC_W'(p);
  endfunction

  // Control state
  logic [2:0]        r_state;
  logic [2:0]        r_stride;
  logic              r_relu;
  logic [ADDR_W-1:0] r_img_base;
  logic [ADDR_W-1:0] r_ker_base;
  logic [TAP_W-1:0]  r_tap;
  logic [KC_W-1:0]   r_kr;
  logic [KC_W-1:0]   r_kc;
  logic [ADDR_W-1:0] r_row_pos;
  logic [ADDR_W-1:0] r_col_pos;
  logic [7:0]        r_orow;
  logic [7:0]        r_ocol;

  // Datapath state
  logic signed [DATA_W-1:0] r_kern [NTAP];
  logic signed [ACC_W-1:0]  r_acc;

  logic [TAP_W-1:0]          w_tap_m1;
  logic [IDX_W-1:0]          w_kidx;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic                      w_tap_rd;
  logic                      w_last_tap;
  logic                      w_col_last;
  logic                      w_row_last;
  logic [ADDR_W-1:0]         w_img_row;
  logic [ADDR_W-1:0]         w_stride_ext;

  // A read is issued in the first NTAP cycles of LOAD/FETCH; the extra cycle
  // only absorbs the data returning from the final read.
  assign w_tap_rd   = (r_tap < TAP_W'(NTAP));
  assign w_last_tap = (r_tap == TAP_W'(NTAP));
  assign w_tap_m1   = r_tap - TAP_W'(1);
  assign w_kidx     = IDX_W'(w_tap_m1);

  assign w_prod     = r_kern[w_kidx] * i_img_data;
  assign w_prod_ext = widen_prod(w_prod);

  // The window is the last one in a row/column when the next stride step
  // would no longer fit the kernel inside the image; this avoids a divider.
  assign w_stride_ext = ADDR_W'(r_stride);
  assign w_col_last   = (r_col_pos + w_stride_ext) > ADDR_W'(IMG_W - KSIZE);
  assign w_row_last   = (r_row_pos + w_stride_ext) > ADDR_W'(IMG_H - KSIZE);

  assign w_img_row  = r_row_pos + ADDR_W'(r_kr);

  assign o_ker_rd    = (r_state == S_LOAD)  && w_tap_rd;
  assign o_img_rd    = (r_state == S_FETCH) && w_tap_rd;
  assign o_ker_addr  = r_ker_base + ADDR_W'(r_tap);
  assign o_img_addr  = r_img_base + w_img_row * ADDR_W'(IMG_W) + r_col_pos + ADDR_W'(r_kc);
  assign o_res_valid = (r_state == S_OUT);
  assign o_res_data  = (r_state == S_OUT) ? relu_clamp(r_acc, r_relu) : '0;
  assign o_res_row   = r_orow;
  assign o_res_col   = r_ocol;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

  // Control: sequencing, counters and window position
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_stride   <= 3'd1;
      r_relu     <= 1'b0;
      r_img_base <= '0;
      r_ker_base <= '0;
      r_tap      <= '0;
      r_kr       <= '0;
      r_kc       <= '0;
      r_row_pos  <= '0;
      r_col_pos  <= '0;
      r_orow     <= '0;
      r_ocol     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_stride   <= (i_stride == 3'd0) ? 3'd1 : i_stride;
            r_relu     <= i_relu;
            r_img_base <= i_img_base;
            r_ker_base <= i_ker_base;
            r_tap      <= '0;
            r_kr       <= '0;
            r_kc       <= '0;
            r_row_pos  <= '0;
            r_col_pos  <= '0;
            r_orow     <= '0;
            r_ocol     <= '0;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (w_last_tap) begin
            r_tap   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_tap <= r_tap + TAP_W'(1);
          end
        end

        S_FETCH: begin
          if (w_last_tap) begin
            r_tap   <= '0;
            r_state <= S_OUT;
          end else begin
            r_tap <= r_tap + TAP_W'(1);
            // Raster walk over the window; wraps back to (0,0) after the
            // final tap so the next window starts clean.
            if (r_kc == KC_W'(KSIZE-1)) begin
              r_kc <= '0;
              r_kr <= (r_kr == KC_W'(KSIZE-1)) ? '0 : r_kr + KC_W'(1);
            end else begin
              r_kc <= r_kc + KC_W'(1);
            end
          end
        end

        S_OUT: begin
          if (i_res_ready) begin
            if (w_col_last) begin
              if (w_row_last) begin
                r_state <= S_DONE;
              end else begin
                r_ocol    <= '0;
                r_col_pos <= '0;
                r_orow    <= r_orow + 8'd1;
                r_row_pos <= r_row_pos + w_stride_ext;
                r_state   <= S_FETCH;
              end
            end else begin
              r_ocol    <= r_ocol + 8'd1;
              r_col_pos <= r_col_pos + w_stride_ext;
              r_state   <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: kernel capture and multiply-accumulate, one cycle behind reads
  always_ff @(posedge i_clk) begin
    if (r_state == S_LOAD && r_tap != '0) begin
      r_kern[w_kidx] <= i_ker_data;
    end
    if (r_state == S_FETCH && r_tap != '0) begin
      r_acc <= (r_tap == TAP_W'(1)) ? w_prod_ext : r_acc + w_prod_ext;
    end
  end

endmodule

// File: tb/tb_conv2d_engine.sv
module tb_conv2d_engine;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int AW   = 16;
  localparam int NT   = K*K;
  localparam int ACCW = 2*DW + $clog2(NT);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   i_start;
  logic [2:0]             i_stride;
  logic                   i_relu;
  logic [AW-1:0]          i_img_base;
  logic [AW-1:0]          i_ker_base;
  logic [AW-1:0]          o_ker_addr;
  logic                   o_ker_rd;
  logic signed [DW-1:0]   ker_data = '0;
  logic [AW-1:0]          o_img_addr;
  logic                   o_img_rd;
  logic signed [DW-1:0]   img_data = '0;
  logic signed [ACCW-1:0] o_res_data;
  logic [7:0]             o_res_row;
  logic [7:0]             o_res_col;
  logic                   o_res_valid;
  logic                   i_res_ready = 1'b1;
  logic                   o_busy;
  logic                   o_done;

  always #5 clk = ~clk;

  conv2d_engine #(
    .DATA_W(DW), .KSIZE(K), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_stride(i_stride),
    .i_relu(i_relu), .i_img_base(i_img_base), .i_ker_base(i_ker_base),
    .o_ker_addr(o_ker_addr), .o_ker_rd(o_ker_rd), .i_ker_data(ker_data),
    .o_img_addr(o_img_addr), .o_img_rd(o_img_rd), .i_img_data(img_data),
    .o_res_data(o_res_data), .o_res_row(o_res_row), .o_res_col(o_res_col),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Memories with one-cycle read latency
  logic signed [DW-1:0] kmem [256];
  logic signed [DW-1:0] imem [1024];

  always @(posedge clk) begin
    if (o_ker_rd) ker_data <= kmem[o_ker_addr[7:0]];
    if (o_img_rd) img_data <= imem[o_img_addr[9:0]];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int     row;
    int     col;
    longint data;
  } res_t;

  res_t   exp_q[$];
  res_t   e;
  longint got_data[$];
  int     done_cnt;
  int     ready_mode = 0;
  int     stall_left = 0;
  longint cyc = 0;
  longint last_hs = -1;

  always @(posedge clk) cyc++;

  // Reference: direct sum over the window, ReLU applied afterwards
  function automatic longint model_pix(int kb, int ib, int s, int r, int c, bit relu);
    longint acc = 0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        acc += longint'(kmem[kb + kr*K + kc]) *
               longint'(imem[ib + (r*s + kr)*W + c*s + kc]);
    if (relu && acc < 0) acc = 0;
    return acc;
  endfunction

  task automatic build_expected(int kb, int ib, int s, bit relu);
    int se, ow, oh;
    res_t x;
    se = (s == 0) ? 1 : s;
    ow = (W - K)/se + 1;
    oh = (H - K)/se + 1;
    exp_q.delete();
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        x.row = r; x.col = c; x.data = model_pix(kb, ib, se, r, c, relu);
        exp_q.push_back(x);
      end
  endtask

  // Ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: i_res_ready = 1'b1;
      1: i_res_ready = 1'($urandom_range(0, 1));
      default: begin
        if (o_res_valid && stall_left > 0) begin
          i_res_ready = 1'b0;
          stall_left--;
        end else begin
          i_res_ready = 1'b1;
        end
      end
    endcase
  end

  // Compare process
  logic                   stall_prev = 1'b0;
  logic signed [ACCW-1:0] snap_data;
  logic [7:0]             snap_row, snap_col;
  logic [AW-1:0]          snap_iaddr, snap_kaddr;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_data", o_res_data, snap_data);
        check("stall_row", o_res_row, snap_row);
        check("stall_col", o_res_col, snap_col);
        check("stall_img_addr", o_img_addr, snap_iaddr);
        check("stall_ker_addr", o_ker_addr, snap_kaddr);
        check("stall_img_rd", o_img_rd, 0);
        check("stall_ker_rd", o_ker_rd, 0);
        check("stall_valid", o_res_valid, 1);
      end
      if (o_res_valid && i_res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", o_res_data, e.data);
          check("res_row", o_res_row, e.row);
          check("res_col", o_res_col, e.col);
        end
        got_data.push_back(longint'(o_res_data));
        if (ready_mode == 0 && last_hs >= 0) check("throughput", cyc - last_hs, NT + 2);
        last_hs = cyc;
      end
      stall_prev = o_res_valid && !i_res_ready;
      snap_data  = o_res_data;
      snap_row   = o_res_row;
      snap_col   = o_res_col;
      snap_iaddr = o_img_addr;
      snap_kaddr = o_ker_addr;
      if (o_done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!o_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      check("done_timeout", 0, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  task automatic run(int kb, int ib, int s, bit relu, int mode, bit busy_start);
    build_expected(kb, ib, s, relu);
    got_data.delete();
    done_cnt   = 0;
    last_hs    = -1;
    ready_mode = mode;
    stall_left = 5;
    @(posedge clk); #1;
    i_stride   = 3'(s);
    i_relu     = relu;
    i_ker_base = AW'(kb);
    i_img_base = AW'(ib);
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    if (busy_start) begin
      repeat (15) @(posedge clk);
      #1;
      i_start    = 1'b1;
      i_stride   = 3'd7;
      i_relu     = ~relu;
      i_img_base = AW'(0);
      i_ker_base = AW'(0);
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    wait_done();
    @(posedge clk); #1;
    check("idle_after_done", o_busy, 0);
    check("done_one_cycle", o_done, 0);
    check("done_count", done_cnt, 1);
    check("results_left", exp_q.size(), 0);
    ready_mode = 0;
  endtask

  task automatic check_all(input string name, longint v, int n);
    check({name, "_count"}, got_data.size(), n);
    for (int i = 0; i < got_data.size(); i++) check(name, got_data[i], v);
  endtask

  task automatic fill_scn1();
    for (int i = 0; i < NT; i++) kmem[10 + i] = 8'sd1;
    for (int i = 0; i < W*H; i++) imem[100 + i] = 8'sd1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) kmem[i] = '0;
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    rst_n = 1'b0; i_start = 1'b0; i_stride = '0; i_relu = 1'b0;
    i_img_base = '0; i_ker_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_res_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_ker_rd", o_ker_rd, 0);
    check("rst_img_rd", o_img_rd, 0);
    check("rst_ker_addr", o_ker_addr, 0);
    check("rst_img_addr", o_img_addr, 0);
    check("rst_data", o_res_data, 0);
    rst_n = 1'b1;

    // All-ones kernel over all-ones image
    fill_scn1();
    run(10, 100, 1, 0, 0, 0);
    check_all("ones", 9, 9);

    // Centre-tap kernel, ramp image, stride 2
    for (int i = 0; i < NT; i++) kmem[20 + i] = (i == 4) ? 8'sd1 : 8'sd0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) imem[200 + r*W + c] = 8'(r*5 + c);
    run(20, 200, 2, 0, 0, 0);
    check("ramp_count", got_data.size(), 4);
    if (got_data.size() == 4) begin
      check("ramp0", got_data[0], 6);
      check("ramp1", got_data[1], 8);
      check("ramp2", got_data[2], 16);
      check("ramp3", got_data[3], 18);
    end

    // Same run with a 5-cycle stall on the first result
    run(20, 200, 2, 0, 2, 0);
    check("stall_count", got_data.size(), 4);
    if (got_data.size() == 4) begin
      check("stall_r0", got_data[0], 6);
      check("stall_r3", got_data[3], 18);
    end

    // Negative kernel, saturated-high image, then ReLU
    for (int i = 0; i < NT; i++) kmem[40 + i] = -8'sd1;
    for (int i = 0; i < W*H; i++) imem[300 + i] = 8'sd127;
    run(40, 300, 1, 0, 0, 0);
    check_all("neg", -1143, 9);
    run(40, 300, 1, 1, 0, 0);
    check_all("relu", 0, 9);

    // Reset asserted mid-FETCH
    begin
      int n = 0;
      exp_q.delete();
      @(posedge clk); #1;
      i_stride = 3'd1; i_relu = 1'b0; i_ker_base = AW'(10); i_img_base = AW'(100);
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      while (!o_img_rd && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("reach_fetch", o_img_rd, 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_valid", o_res_valid, 0);
      check("mid_rst_img_rd", o_img_rd, 0);
      check("mid_rst_ker_rd", o_ker_rd, 0);
      check("mid_rst_img_addr", o_img_addr, 0);
      check("mid_rst_ker_addr", o_ker_addr, 0);
      check("mid_rst_data", o_res_data, 0);
      check("mid_rst_row", o_res_row, 0);
      check("mid_rst_col", o_res_col, 0);
      check("mid_rst_done", o_done, 0);
      rst_n = 1'b1;
    end
    run(10, 100, 1, 0, 0, 0);
    check_all("after_rst", 9, 9);

    // Start pulses while busy are ignored
    run(10, 100, 1, 0, 0, 1);
    check_all("busy_start", 9, 9);

    // Stride 0 behaves as stride 1
    run(20, 200, 0, 0, 0, 0);
    check("s0_count", got_data.size(), 9);
    if (got_data.size() == 9) begin
      check("s0_first", got_data[0], 6);
      check("s0_last", got_data[8], 18);
    end

    // Stride 7 yields a single window
    for (int i = 0; i < NT; i++) kmem[60 + i] = 8'($urandom);
    for (int i = 0; i < W*H; i++) imem[500 + i] = 8'($urandom);
    run(60, 500, 7, 0, 0, 0);
    check("s7_count", got_data.size(), 1);

    // Randomised runs with random back-pressure
    for (int t = 0; t < 8; t++) begin
      int kb, ib;
      kb = $urandom_range(0, 200);
      ib = $urandom_range(0, 900);
      for (int i = 0; i < NT; i++) kmem[kb + i] = 8'($urandom);
      for (int i = 0; i < W*H; i++) imem[ib + i] = 8'($urandom);
      run(kb, ib, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
